// File: rtl/rwc_pkg.sv
// rtl/rwc_pkg.sv - shared encodings and defaults for the rwc_ctrl challenge sequencer
//
// Purpose: state encoding, default generator widths and the challenge clear
// value, imported by rwc_vote and rwc_sched.
package rwc_pkg;

    // Default widths of the read-write-collision generator interface.
    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DATA_W = 32;

    // Fill bit for challenge/response words when nothing meaningful is driven.
    // It is replicated to the word width so one constant serves any DATA_W.
    localparam logic CHALLENGE_CLEAR = 1'b0;

    // Sequencer states.
    typedef logic [2:0] state_t;
    localparam state_t IDLE      = 3'd0;
    localparam state_t ISSUE     = 3'd1;
    localparam state_t WAIT_BUSY = 3'd2;
    localparam state_t WAIT_DONE = 3'd3;
    localparam state_t SAMPLE    = 3'd4;
    localparam state_t EMIT      = 3'd5;

endpackage

// File: rtl/rwc_vote.sv
// rtl/rwc_vote.sv - per-bit collision vote counters with majority output
//
// Purpose: DATA_W independent counters, one per response bit. Each counts how
// many evaluations saw a collision on its bit. REPEAT <= 15 bounds the count,
// so the counters need no saturation.
// Ports:
//   clk, resetn : clock, asynchronous active-low reset
//   clr         : zero all counters (wins over inc)
//   inc         : add flag[i] to counter i
//   flag        : per-bit collision flags for this evaluation
//   maj         : maj[i] = counter i > REPEAT/2
module rwc_vote
    import rwc_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REPEAT = 5
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              clr,
    input  logic              inc,
    input  logic [DATA_W-1:0] flag,
    output logic [DATA_W-1:0] maj
);

    localparam int CNT_W = $clog2(REPEAT + 1);

    logic [CNT_W-1:0] cnt_q [DATA_W];
    logic [CNT_W-1:0] cnt_d [DATA_W];

    always_comb begin
        for (int i = 0; i < DATA_W; i++) begin
            cnt_d[i] = cnt_q[i];
            if (clr) begin
                cnt_d[i] = '0;
            end else if (inc && flag[i]) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DATA_W; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DATA_W; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // REPEAT is odd, so a strict majority never ties.
    always_comb begin
        for (int i = 0; i < DATA_W; i++) begin
            maj[i] = (cnt_q[i] > CNT_W'(REPEAT / 2));
        end
    end

endmodule

// File: rtl/rwc_sched.sv
// rtl/rwc_sched.sv - command sequencer and majority voter for the rwc_ctrl PUF generator
//
// Purpose: takes a command of cmd_count challenges from cmd_addr, fires each
// challenge REPEAT times on the generator, majority-votes rsp_pos ^ rsp_neg
// per bit and streams one voted word per address on the resp_* port.
// Ports:
//   clk, resetn             : clock (shared with generator), async active-low reset
//   cmd_valid/ready         : command handshake; cmd_addr/data/count payload
//   gen_enable              : one-cycle start pulse to the generator
//   gen_addr, gen_data      : challenge address/data, held for the whole word
//   gen_available           : generator idle flag
//   gen_rsp_pos, gen_rsp_neg: generator edge samples
//   resp_valid/ready        : response handshake
//   resp_data/addr/last/err : voted word, its address, last-of-command, timeout abort
//   busy                    : a command is in progress
module rwc_sched
    import rwc_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int REPEAT  = 5,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    input  logic [ADDR_W:0]   cmd_count,
    output logic              gen_enable,
    output logic [ADDR_W-1:0] gen_addr,
    output logic [DATA_W-1:0] gen_data,
    input  logic              gen_available,
    input  logic [DATA_W-1:0] gen_rsp_pos,
    input  logic [DATA_W-1:0] gen_rsp_neg,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic [ADDR_W-1:0] resp_addr,
    output logic              resp_last,
    output logic              resp_err,
    output logic              busy
);

    localparam int REP_W = $clog2(REPEAT + 1);
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    state_t            state_q,  state_d;
    logic [ADDR_W-1:0] addr_q,   addr_d;
    logic [DATA_W-1:0] data_q,   data_d;
    logic [ADDR_W:0]   remain_q, remain_d;
    logic [REP_W-1:0]  rep_q,    rep_d;
    logic [TMO_W-1:0]  tmo_q,    tmo_d;
    logic              err_q,    err_d;

    logic              cmd_take;
    logic              wait_expired;
    logic              word_last;
    logic              in_wait;
    logic              vote_clr;
    logic              vote_inc;
    logic [DATA_W-1:0] vote_maj;

    assign cmd_take     = cmd_valid && (state_q == IDLE) && (cmd_count != '0);
    // tmo_q counts cycles already spent in the wait state; this is the last one.
    assign wait_expired = (tmo_q == TMO_W'(TIMEOUT - 1));
    // A timeout abort always ends the command.
    assign word_last    = err_q || (remain_q == (ADDR_W + 1)'(1));
    assign in_wait      = (state_q == WAIT_BUSY) || (state_q == WAIT_DONE);

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            data_q   <= {DATA_W{CHALLENGE_CLEAR}};
            remain_q <= '0;
            rep_q    <= '0;
            tmo_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            remain_q <= remain_d;
            rep_q    <= rep_d;
            tmo_q    <= tmo_d;
            err_q    <= err_d;
        end
    end

    // ---------------- next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (cmd_take) state_d = ISSUE;
            ISSUE:     state_d = WAIT_BUSY;
            // Progress wins over an expiring timeout on the same cycle.
            WAIT_BUSY: begin
                if (!gen_available)    state_d = WAIT_DONE;
                else if (wait_expired) state_d = EMIT;
            end
            WAIT_DONE: begin
                if (gen_available)     state_d = SAMPLE;
                else if (wait_expired) state_d = EMIT;
            end
            SAMPLE:    state_d = (rep_q == REP_W'(REPEAT - 1)) ? EMIT : ISSUE;
            EMIT:      if (resp_ready) state_d = word_last ? IDLE : ISSUE;
            default:   state_d = IDLE;
        endcase
    end

    // ---------------- datapath registers ----------------
    always_comb begin
        addr_d   = addr_q;
        data_d   = data_q;
        remain_d = remain_q;
        rep_d    = rep_q;
        err_d    = err_q;
        vote_clr = 1'b0;
        vote_inc = 1'b0;
        // Re-entering a wait state (or leaving one) restarts the count.
        tmo_d    = (in_wait && (state_d == state_q)) ? tmo_q + TMO_W'(1) : '0;

        case (state_q)
            IDLE: begin
                if (cmd_take) begin
                    addr_d   = cmd_addr;
                    data_d   = cmd_data;
                    remain_d = cmd_count;
                    rep_d    = '0;
                    err_d    = 1'b0;
                    vote_clr = 1'b1;
                end
            end
            WAIT_BUSY, WAIT_DONE: begin
                if (state_d == EMIT) err_d = 1'b1;
            end
            SAMPLE: begin
                rep_d    = rep_q + REP_W'(1);
                vote_inc = 1'b1;
            end
            EMIT: begin
                // gen_addr only moves here, between words, so the generator's
                // BRAM address is steady for all evaluations of a word.
                if (resp_ready && !word_last) begin
                    addr_d   = addr_q + ADDR_W'(1);
                    remain_d = remain_q - (ADDR_W + 1)'(1);
                    rep_d    = '0;
                    vote_clr = 1'b1;
                end
            end
            default: ;
        endcase
    end

    rwc_vote #(
        .DATA_W (DATA_W),
        .REPEAT (REPEAT)
    ) u_vote (
        .clk    (clk),
        .resetn (resetn),
        .clr    (vote_clr),
        .inc    (vote_inc),
        .flag   (gen_rsp_pos ^ gen_rsp_neg),
        .maj    (vote_maj)
    );

    // ---------------- outputs ----------------
    assign gen_addr = addr_q;
    assign gen_data = data_q;

    always_comb begin
        cmd_ready  = (state_q == IDLE);
        busy       = (state_q != IDLE);
        gen_enable = (state_q == ISSUE);
        resp_valid = (state_q == EMIT);
        resp_last  = (state_q == EMIT) && word_last;
        resp_err   = (state_q == EMIT) && err_q;
        resp_addr  = (state_q == EMIT) ? addr_q : '0;
        resp_data  = ((state_q == EMIT) && !err_q) ? vote_maj : {DATA_W{CHALLENGE_CLEAR}};
    end

endmodule

// File: tb/tb_rwc_sched.sv
// tb/tb_rwc_sched.sv - self-checking bench for rwc_sched with a behavioural generator and scoreboard
module tb_rwc_sched;

    localparam int AW  = 10;
    localparam int DW  = 32;
    localparam int REP = 5;
    localparam int TMO = 15;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_data = '0;
    logic [AW:0]   cmd_count = '0;
    logic          gen_enable;
    logic [AW-1:0] gen_addr;
    logic [DW-1:0] gen_data;
    logic          gen_available = 1'b1;
    logic [DW-1:0] gen_rsp_pos = '0;
    logic [DW-1:0] gen_rsp_neg = '0;
    logic          resp_valid;
    logic          resp_ready = 1'b1;
    logic [DW-1:0] resp_data;
    logic [AW-1:0] resp_addr;
    logic          resp_last;
    logic          resp_err;
    logic          busy;

    always #5 clk = ~clk;

    rwc_sched #(.ADDR_W(AW), .DATA_W(DW), .REPEAT(REP), .TIMEOUT(TMO)) dut (
        .clk(clk), .resetn(resetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_data(cmd_data), .cmd_count(cmd_count),
        .gen_enable(gen_enable), .gen_addr(gen_addr), .gen_data(gen_data),
        .gen_available(gen_available), .gen_rsp_pos(gen_rsp_pos), .gen_rsp_neg(gen_rsp_neg),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_addr(resp_addr), .resp_last(resp_last), .resp_err(resp_err), .busy(busy)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          last;
        logic          err;
    } rsp_t;

    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    rsp_t          sb[$];
    logic [DW-1:0] pats[$];
    int            run_idx = 0;
    int            enables = 0;
    int            busy_cnt = 0;
    bit            stuck = 0;
    logic [AW-1:0] cmd_base = '0;
    logic [DW-1:0] cmd_dat = '0;
    logic [AW-1:0] held_addr = '0;
    int            n_resp = 0;
    int            en_cycle = 0;
    int            first_valid_cyc = -1;
    logic [DW-1:0] got_data;
    logic [AW-1:0] got_addr;
    logic          got_last;
    logic          got_err;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Majority per bit over one word's REP evaluations, straight from the XOR patterns.
    function automatic logic [DW-1:0] model_vote(input int first);
        logic [DW-1:0] r;
        int ones;
        r = '0;
        for (int b = 0; b < DW; b++) begin
            ones = 0;
            for (int k = 0; k < REP; k++)
                if (first + k < pats.size() && pats[first + k][b]) ones++;
            r[b] = (ones * 2 > REP);
        end
        return r;
    endfunction

    // Generator: after a pulse, available drops, stays low 5 cycles, then rises
    // with pos ^ neg equal to the next pattern. A stuck generator never drops.
    always @(negedge clk) begin
        logic [AW-1:0] exp_a;
        logic [DW-1:0] noise;
        if (!resetn) begin
            busy_cnt      = 0;
            gen_available = 1'b1;
        end else begin
            if (busy_cnt > 0) begin
                chk("gen_addr_steady", gen_addr, held_addr);
                busy_cnt--;
                if (busy_cnt == 0) gen_available = 1'b1;
            end
            if (gen_enable) begin
                exp_a = AW'(cmd_base + AW'(run_idx / REP));
                chk("gen_addr", gen_addr, exp_a);
                chk("gen_data", gen_data, cmd_dat);
                enables++;
                en_cycle = cyc;
                if (stuck) begin
                    gen_rsp_pos = '1;
                    gen_rsp_neg = '0;
                end else begin
                    noise         = $urandom;
                    gen_rsp_neg   = noise;
                    gen_rsp_pos   = noise ^ ((run_idx < pats.size()) ? pats[run_idx] : '0);
                    gen_available = 1'b0;
                    busy_cnt      = 5;
                    held_addr     = gen_addr;
                end
                run_idx++;
            end
        end
    end

    // Response compare against the scoreboard front on every valid cycle.
    always @(negedge clk) begin
        if (resetn) begin
            chk("cmd_ready_vs_busy", cmd_ready, !busy);
            if (resp_valid) begin
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp: got addr %0h data %0h, required no response", resp_addr, resp_data);
                end else begin
                    chk("resp_addr", resp_addr, sb[0].addr);
                    chk("resp_data", resp_data, sb[0].data);
                    chk("resp_last", resp_last, sb[0].last);
                    chk("resp_err",  resp_err,  sb[0].err);
                    if (resp_ready) begin
                        got_data = resp_data;
                        got_addr = resp_addr;
                        got_last = resp_last;
                        got_err  = resp_err;
                        void'(sb.pop_front());
                        n_resp++;
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outs(input string tag);
        chk({tag, "_cmd_ready"}, cmd_ready, 1'b1);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_gen_enable"}, gen_enable, 1'b0);
        chk({tag, "_gen_addr"}, gen_addr, '0);
        chk({tag, "_gen_data"}, gen_data, '0);
        chk({tag, "_resp_valid"}, resp_valid, 1'b0);
        chk({tag, "_resp_data"}, resp_data, '0);
        chk({tag, "_resp_addr"}, resp_addr, '0);
        chk({tag, "_resp_last"}, resp_last, 1'b0);
        chk({tag, "_resp_err"}, resp_err, 1'b0);
    endtask

    task automatic set_const(input int n, input logic [DW-1:0] v);
        pats.delete();
        for (int i = 0; i < n; i++) pats.push_back(v);
    endtask

    task automatic set_rand(input int n);
        pats.delete();
        for (int i = 0; i < n; i++) pats.push_back($urandom);
    endtask

    task automatic run_cmd(input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [AW:0] n, input bit stk);
        bit acc;
        rsp_t r;
        stuck = stk;
        run_idx = 0;
        enables = 0;
        first_valid_cyc = -1;
        cmd_base = a;
        cmd_dat = d;
        if (stk) begin
            if (n != 0) begin
                r = '{addr: a, data: '0, last: 1'b1, err: 1'b1};
                sb.push_back(r);
            end
        end else begin
            for (int w = 0; w < int'(n); w++) begin
                r = '{addr: AW'(a + AW'(w)), data: model_vote(w * REP),
                      last: (w == int'(n) - 1), err: 1'b0};
                sb.push_back(r);
            end
        end
        cmd_valid = 1'b1;
        cmd_addr = a;
        cmd_data = d;
        cmd_count = n;
        acc = 0;
        for (int k = 0; k < 20 && !acc; k++) begin
            if (cmd_ready) acc = 1;
            step();
        end
        cmd_valid = 1'b0;
        chk("cmd_accepted", acc, 1'b1);
    endtask

    task automatic wait_done(input int bound);
        bit done;
        done = 0;
        for (int k = 0; k < bound && !done; k++) begin
            step();
            if (sb.size() == 0 && !busy) done = 1;
        end
        chk("cmd_completes", done, 1'b1);
    endtask

    initial begin
        int n0;
        int e0;
        bit seen;
        repeat (3) step();
        check_reset_outs("reset");
        resetn = 1'b1;
        step();

        // Single challenge
        set_const(REP, 32'h0000FFFF);
        run_cmd(10'h010, 32'hA5A5A5A5, 11'd1, 0);
        wait_done(300);
        chk("t1_enables", enables, 5);
        chk("t1_data", got_data, 32'h0000FFFF);
        chk("t1_addr", got_addr, 10'h010);
        chk("t1_last", got_last, 1'b1);
        chk("t1_err", got_err, 1'b0);

        // Majority 3 of 5, then 2 of 5
        pats = '{32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF};
        run_cmd(10'h020, 32'h12345678, 11'd1, 0);
        wait_done(300);
        chk("t2_maj3", got_data, 32'hFFFFFFFF);
        pats = '{32'h0, 32'hFFFFFFFF, 32'h0, 32'h0, 32'hFFFFFFFF};
        run_cmd(10'h021, 32'h87654321, 11'd1, 0);
        wait_done(300);
        chk("t2_maj2", got_data, 32'h00000000);

        // Burst with address wrap, mixed bit patterns
        set_rand(3 * REP);
        n0 = n_resp;
        run_cmd(10'h3FE, 32'hCAFEF00D, 11'd3, 0);
        wait_done(600);
        chk("t3_words", n_resp - n0, 3);
        chk("t3_enables", enables, 15);
        chk("t3_last_addr", got_addr, 10'h000);
        chk("t3_last", got_last, 1'b1);

        // Backpressure
        set_rand(2 * REP);
        resp_ready = 1'b0;
        run_cmd(10'h200, 32'h0BADBEEF, 11'd2, 0);
        seen = 0;
        for (int k = 0; k < 300 && !seen; k++) begin
            step();
            if (resp_valid) seen = 1;
        end
        chk("t4_first_valid", seen, 1'b1);
        repeat (20) step();
        chk("t4_held_valid", resp_valid, 1'b1);
        chk("t4_no_new_enable", enables, 5);
        resp_ready = 1'b1;
        wait_done(300);
        chk("t4_enables", enables, 10);
        chk("t4_last_addr", got_addr, 10'h201);

        // Timeout: generator never goes busy
        run_cmd(10'h123, 32'h55AA55AA, 11'd2, 1);
        wait_done(100);
        chk("t5_err", got_err, 1'b1);
        chk("t5_last", got_last, 1'b1);
        chk("t5_data", got_data, 32'h0);
        chk("t5_addr", got_addr, 10'h123);
        chk("t5_enables", enables, 1);
        chk("t5_latency", first_valid_cyc - en_cycle, TMO + 1);
        chk("t5_cmd_ready", cmd_ready, 1'b1);
        stuck = 0;

        // Zero count: accepted and dropped
        n0 = n_resp;
        run_cmd(10'h055, 32'h11111111, 11'd0, 0);
        repeat (10) step();
        chk("t6_enables", enables, 0);
        chk("t6_no_resp", n_resp - n0, 0);
        chk("t6_busy", busy, 1'b0);

        // Reset during WAIT_DONE
        set_rand(2 * REP);
        run_cmd(10'h155, 32'hDEADBEEF, 11'd2, 0);
        seen = 0;
        for (int k = 0; k < 100 && !seen; k++) begin
            step();
            if (busy_cnt == 2) seen = 1;
        end
        chk("t7_reached_wait", seen, 1'b1);
        #2;
        resetn = 1'b0;
        #1;
        check_reset_outs("midrst");
        sb.delete();
        e0 = enables;
        repeat (5) step();
        chk("t7_no_enable", enables, e0);
        resetn = 1'b1;
        step();
        chk("t7_busy", busy, 1'b0);

        // Recovery after reset
        set_const(REP, 32'h0F0F0F0F);
        run_cmd(10'h001, 32'h00000001, 11'd1, 0);
        wait_done(300);
        chk("t8_data", got_data, 32'h0F0F0F0F);
        chk("t8_addr", got_addr, 10'h001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rwc_sched.md
Name: rwc_sched

Overview:
- Sequencer for the read-write-collision PUF generator (rwc_ctrl).
- Accepts a command of N consecutive challenges starting at a base address with one challenge data word.
- Fires each challenge REPEAT times and majority-votes the per-bit collision flag (rsp_pos XOR rsp_neg).
- Streams one voted response word per address out on a valid/ready port. Sits between the host/UART command layer and the generator.

Parameters:
ADDR_W, 10, generator address width
DATA_W, 32, challenge/response width
REPEAT, 5, evaluations per challenge; odd, 1..15
TIMEOUT, 15, max clk cycles spent in each generator wait state before abort

Ports:
clk  in  1  system clock; same clock as the generator's clk
resetn  in  1  asynchronous active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when valid&ready
cmd_addr  in  ADDR_W  first challenge address
cmd_data  in  DATA_W  challenge data written at every address
cmd_count  in  ADDR_W+1  number of addresses; 0 = accept and drop
gen_enable  out  1  one-cycle start pulse to generator
gen_addr  out  ADDR_W  challenge address (cha_addr)
gen_data  out  DATA_W  challenge data (cha_data)
gen_available  in  1  generator idle flag
gen_rsp_pos  in  DATA_W  generator rising-edge sample
gen_rsp_neg  in  DATA_W  generator falling-edge sample
resp_valid  out  1  response word valid
resp_ready  in  1  downstream accepts
resp_data  out  DATA_W  voted collision word
resp_addr  out  ADDR_W  address of resp_data
resp_last  out  1  final word of the command
resp_err  out  1  word aborted by timeout
busy  out  1  command in progress (state != IDLE)

Behaviour:
- Reset (async assert, sync release): state IDLE. cmd_ready=1; gen_enable=0; gen_addr=0; gen_data=0; resp_valid=0; resp_data=0; resp_addr=0; resp_last=0; resp_err=0; busy=0. All vote counters are 0.
- States:
  - IDLE: cmd_ready=1. On valid&ready with count>0, latch addr/data/count, clear the vote counters and the repeat counter, then go to ISSUE. With count=0, stay in IDLE and produce no output.
  - ISSUE: gen_enable=1 for exactly one cycle, then go to WAIT_BUSY.
  - WAIT_BUSY: wait for gen_available=0, then go to WAIT_DONE.
  - WAIT_DONE: wait for gen_available=1, then go to SAMPLE.
  - SAMPLE: one cycle. Per bit i, vote[i] += (rsp_pos[i]^rsp_neg[i]); repeat++. If repeat==REPEAT go to EMIT, else go to ISSUE.
  - EMIT: resp_valid=1. resp_data[i] = (vote[i] > REPEAT/2). resp_last = (remaining==1). On resp_ready: if last, go to IDLE; else addr++, remaining--, clear votes and repeat, go to ISSUE.
- gen_addr and gen_data are registered and held constant from command accept until leaving EMIT. The generator's BRAM port uses the address continuously, so it must never change mid-evaluation.
- Address increments modulo 2^ADDR_W: 0x3FF+1 → 0x000.
- Vote counters are DATA_W × $clog2(REPEAT+1) bits and never overflow because REPEAT≤15.
- Timeout: a cycle counter resets on entry to WAIT_BUSY and WAIT_DONE. Reaching TIMEOUT in either state goes to EMIT with resp_err=1, resp_last=1, resp_data=0, and resp_addr = current address. The rest of the command is discarded.
- resp_* outputs are stable while resp_valid=1 and resp_ready=0. cmd_ready=0 whenever busy.
- Latency with a generator that responds immediately: ISSUE → available low 1 cycle later → high 4 cycles later. SAMPLE follows, so each evaluation takes about 7 cycles.
- Reset asserted mid-command returns to IDLE immediately. There is no partial response and the generator is not driven afterwards (gen_enable=0).

Decomposition:
- Package rwc_pkg holds:
  - the state encoding localparams IDLE/ISSUE/WAIT_BUSY/WAIT_DONE/SAMPLE/EMIT;
  - the default widths ADDR_W=10 and DATA_W=32;
  - CHALLENGE_CLEAR.
- One sub-module, rwc_vote: DATA_W parallel saturating-free counters with clear/inc/majority output.
- The FSM, address and remaining-count registers, and the timeout counter stay in rwc_sched.

Test Plan:
- Single challenge: cmd addr=0x010, data=0xA5A5A5A5, count=1. The generator model returns pos^neg=0x0000FFFF on every run. Expect exactly 5 gen_enable pulses, then resp_data=0x0000FFFF, resp_addr=0x010, resp_last=1, resp_err=0.
- Majority: the model returns XOR 0xFFFFFFFF on 3 of 5 runs and 0 on 2. Expect resp_data=0xFFFFFFFF. With 2 of 5 runs, expect 0x00000000.
- Burst with wrap: addr=0x3FE, count=3. Expect resp_addr 0x3FE, 0x3FF, 0x000; resp_last only on the third word. gen_addr is constant during each word's 5 runs.
- Backpressure: resp_ready held 0 for 20 cycles in EMIT. Expect resp_valid and data stable, no new gen_enable, then progress after ready.
- Timeout: the model keeps gen_available=1 forever after a pulse. After TIMEOUT=15 cycles expect resp_valid with resp_err=1, resp_last=1, resp_data=0, then IDLE with cmd_ready=1.
- Reset/zero count: count=0 → cmd accepted, no gen_enable, no response. resetn pulsed during WAIT_DONE → all outputs return to reset values at once.
